temp_monitor: RTL and testbench
===============================

// Module: temp_monitor
// PURPOSE
// - Post-processing stage directly downstream of the MCP ADC serial interface: consumes raw 8-bit temperature samples (do bus + strobe).
// - Produces a moving-average temperature, a hysteresis over-temperature alarm (drives leddemux), and BCD digits for lcd_state.
// - Replaces the raw combinational "do > 0x25" compare with a filtered, debounced decision.
// PARAMETERS
// - AVG_LOG2   2      log2 of moving-average window (window = 4 samples); legal 1..4
// - TH_HI      8'h25  alarm set threshold: alarm sets when avg > TH_HI
// - TH_LO      8'h22  alarm clear threshold: alarm clears when avg < TH_LO; TH_LO <= TH_HI required
// PORTS
// - clk         in   1  system clock
// - rst         in   1  asynchronous reset, active-low
// - sample      in   8  raw temperature code from ADC stage
// - sample_vld  in   1  one-cycle strobe, sample valid
// - avg         out  8  current moving average
// - avg_vld     out  1  one-cycle pulse, avg updated
// - alarm       out  1  filtered over-temperature flag (to leddemux)
// - bcd_h       out  4  hundreds digit of last converted avg
// - bcd_t       out  4  tens digit
// - bcd_o       out  4  ones digit
// - bcd_vld     out  1  one-cycle pulse, BCD digits updated
// - busy        out  1  BCD conversion in flight
// - mm_clr      in   1  clear min/max trackers (TEMP_MINMAX_EN only)
// - tmin        out  8  minimum avg since reset/clear (TEMP_MINMAX_EN only)
// - tmax        out  8  maximum avg since reset/clear (TEMP_MINMAX_EN only)
// BEHAVIOUR
// - Reset (rst low, async): all outputs 0, buffer and sum cleared, primed=0, FSM IDLE, pending=0.
// - Averaging: circular buffer 2^AVG_LOG2 x 8, running sum width 8+AVG_LOG2, write pointer wraps modulo window.
// - First sample after reset (primed=0): every buffer entry loaded with sample, sum = sample<<AVG_LOG2, primed=1.
// - Subsequent samples: sum <= sum - buf[wp] + sample; buf[wp] <= sample; wp++ (wrap).
// - avg = sum>>AVG_LOG2 (truncating); avg and avg_vld registered, avg_vld high the cycle after sample_vld.
// - sample_vld every cycle is legal; each strobe produces exactly one avg_vld.
// - Alarm: evaluated on the new avg; set if avg > TH_HI, clear if avg < TH_LO, else hold. Updates same cycle as avg_vld.
// - BCD FSM (sub-module): IDLE -> SHIFT (8 cycles, shift-add-3 double-dabble) -> DONE (bcd_vld=1, digits updated) -> IDLE.
// - Conversion starts in cycle after avg_vld; bcd_vld 9 cycles after avg_vld; busy high in SHIFT and DONE.
// - avg_vld while busy: value held in one-deep pending register (newest overwrites older); converted directly after DONE.
// - bcd_* hold their last value between conversions; never show partial results.
// - Async reset mid-conversion aborts; no bcd_vld is emitted for the aborted value.
// CONFIGURATION
// - Macro TEMP_MINMAX_EN defined: tmin/tmax track avg on every avg_vld.
//   - First avg after reset or mm_clr loads both; mm_clr has priority over a same-cycle update.
// - Macro undefined: tracker logic absent; tmin/tmax tied to 0, mm_clr ignored.
// STRUCTURE
// - Package temp_pkg: BCD FSM state enum (IDLE/SHIFT/DONE), default thresholds 8'h25/8'h22, BCD digit width constant.
// - Sub-module bin2bcd8: sequential 8-bit double-dabble converter (start, bin[7:0] -> done, h/t/o, busy).
// - temp_monitor holds averaging buffer, alarm hysteresis, pending register, min/max trackers.
// TESTING (AVG_LOG2=2, TH_HI=0x25, TH_LO=0x22)
// - Reset: rst low mid-run -> all outputs 0 immediately; first sample 25 -> avg=25 next cycle, bcd 0/2/5 with bcd_vld 9 cycles later.
// - Window: prime 20, then 40,40,40,40 -> avg 25,30,35,40; alarm sets on the avg=40 (0x28) update only.
// - Hysteresis: from alarm=1, feed 35 x4 -> alarm holds at avg 0x23/0x24; feed 30 -> clears once avg < 0x22.
// - Back-to-back: sample_vld 3 consecutive cycles -> 3 avg_vld; only first and last avg converted, bcd_vld twice.
// - Range: sample 255 x4 -> avg 255, bcd 2/5/5; sample 0 -> bcd 0/0/0; no sum overflow.
// - TEMP_MINMAX_EN: avgs 30,50,10 -> tmin=10, tmax=50; mm_clr with avg 40 same cycle -> next avg loads both.

Source files
------------

// File: rtl/temp_pkg.sv
// temp_pkg: BCD FSM states, default alarm thresholds and double-dabble digit adjust
package temp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  localparam logic [7:0] TH_HI_DEF = 8'h25;
  localparam logic [7:0] TH_LO_DEF = 8'h22;
  localparam int BCD_W = 4;
  function automatic logic [BCD_W-1:0] dd_adj(input logic [BCD_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/bin2bcd8.sv
// bin2bcd8: sequential 8-bit double-dabble converter, digits only change when a conversion completes
module bin2bcd8 import temp_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             done,
  output logic [BCD_W-1:0] h,
  output logic [BCD_W-1:0] t,
  output logic [BCD_W-1:0] o,
  output logic             busy
);
  bcd_state_t state, state_nx;
  logic [19:0] sr, sr_sh;
  logic [2:0]  cnt;
  // one double-dabble step: add 3 to every digit >= 5, then shift left
  always_comb sr_sh = {dd_adj(sr[19:16]), dd_adj(sr[15:12]), dd_adj(sr[11:8]), sr[7:0]} << 1;
  // next state; a start seen in DONE chains straight into the next conversion
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SHIFT : IDLE;
      SHIFT:   state_nx = (cnt == 3'd7) ? DONE : SHIFT;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // shift register and digit outputs; digits load only from the final shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      h     <= '0;
      t     <= '0;
      o     <= '0;
    end else begin
      state <= state_nx;
      if (start && state != SHIFT) begin
        sr  <= {12'd0, bin};
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= sr_sh;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) {h, t, o} <= sr_sh[19:8];
      end
    end
  end
  assign done = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: rtl/temp_monitor.sv
// temp_monitor: moving-average filter, hysteresis alarm and BCD readout; TEMP_MINMAX_EN enables min/max tracking
module temp_monitor import temp_pkg::*; #(
  parameter int         AVG_LOG2 = 2,
  parameter logic [7:0] TH_HI    = TH_HI_DEF,
  parameter logic [7:0] TH_LO    = TH_LO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sample,
  input  logic             sample_vld,
  output logic [7:0]       avg,
  output logic             avg_vld,
  output logic             alarm,
  output logic [BCD_W-1:0] bcd_h,
  output logic [BCD_W-1:0] bcd_t,
  output logic [BCD_W-1:0] bcd_o,
  output logic             bcd_vld,
  output logic             busy,
  input  logic             mm_clr,
  output logic [7:0]       tmin,
  output logic [7:0]       tmax
);
  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW  = 8 + AVG_LOG2;
  logic [7:0]          mem [WIN];
  logic [AVG_LOG2-1:0] wp;
  logic [SW-1:0]       sum, sum_nx;
  logic                primed, pend, start;
  logic [7:0]          avg_nx, pend_val, bin;
  // first sample fills the whole window so the average starts at that sample
  always_comb sum_nx = primed ? sum - SW'(mem[wp]) + SW'(sample) : SW'(sample) << AVG_LOG2;
  assign avg_nx = sum_nx[SW-1:AVG_LOG2];
  // window buffer, running sum, registered average and hysteresis alarm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN; i++) mem[i] <= '0;
      wp      <= '0;
      sum     <= '0;
      primed  <= 1'b0;
      avg     <= '0;
      avg_vld <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      avg_vld <= sample_vld;
      if (sample_vld) begin
        for (int i = 0; i < WIN; i++) if (!primed || AVG_LOG2'(i) == wp) mem[i] <= sample;
        if (primed) wp <= wp + 1'b1;
        sum    <= sum_nx;
        avg    <= avg_nx;
        primed <= 1'b1;
        alarm  <= (avg_nx > TH_HI) ? 1'b1 : (avg_nx < TH_LO) ? 1'b0 : alarm;
      end
    end
  end
  // converter accepts work when idle or finishing; the newest average always wins
  assign start = (avg_vld | pend) & (~busy | bcd_vld);
  assign bin   = avg_vld ? avg : pend_val;
  // one-deep holding register for an average that arrives mid-conversion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= 1'b0;
      pend_val <= '0;
    end else if (avg_vld && !start) begin
      pend     <= 1'b1;
      pend_val <= avg;
    end else if (start) begin
      pend <= 1'b0;
    end
  end
  bin2bcd8 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .done  (bcd_vld),
    .h     (bcd_h),
    .t     (bcd_t),
    .o     (bcd_o),
    .busy  (busy)
  );
`ifdef TEMP_MINMAX_EN
  logic mm_first;
  // min/max of published averages; a clear re-arms loading from the next average
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmin     <= '0;
      tmax     <= '0;
      mm_first <= 1'b1;
    end else if (mm_clr) begin
      tmin     <= '0;
      tmax     <= '0;
      mm_first <= 1'b1;
    end else if (avg_vld) begin
      tmin     <= (mm_first || avg < tmin) ? avg : tmin;
      tmax     <= (mm_first || avg > tmax) ? avg : tmax;
      mm_first <= 1'b0;
    end
  end
`else
  logic unused_mm;
  assign unused_mm = mm_clr;
  assign tmin = '0;
  assign tmax = '0;
`endif
endmodule

// File: tb/tb_temp_monitor.sv
// tb_temp_monitor: directed stimulus with queued expectations checked by an independent output monitor
module tb_temp_monitor;
  logic       clk = 1'b0, rst = 1'b0, sample_vld = 1'b0, mm_clr = 1'b0;
  logic [7:0] sample = '0;
  logic [7:0] avg, tmin, tmax;
  logic       avg_vld, alarm, bcd_vld, busy;
  logic [3:0] bcd_h, bcd_t, bcd_o;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct packed {logic [11:0] d; logic [31:0] due;} bcd_e_t;
  logic [8:0] aq[$];
  bcd_e_t     bq[$];
  logic [8:0] ae;
  bcd_e_t     be;

  temp_monitor dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_vld(sample_vld),
    .avg(avg), .avg_vld(avg_vld), .alarm(alarm),
    .bcd_h(bcd_h), .bcd_t(bcd_t), .bcd_o(bcd_o), .bcd_vld(bcd_vld), .busy(busy),
    .mm_clr(mm_clr), .tmin(tmin), .tmax(tmax)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", n, g, e, cyc);
    end
  endfunction

  // issue one sample, queue its expected average/alarm and, if due_off>0, its BCD result and cycle
  task automatic send(input logic [7:0] s, input logic [7:0] ea, input logic eal, input int gap, input int due_off);
    sample = s;
    sample_vld = 1'b1;
    aq.push_back({ea, eal});
    if (due_off > 0) bq.push_back(bcd_e_t'{d: {4'(ea / 100), 4'((ea / 10) % 10), 4'(ea % 10)}, due: 32'(cyc + due_off)});
    @(negedge clk);
    sample_vld = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // monitor: compare every presented output against the oldest queued expectation
  always @(negedge clk) begin
    if (avg_vld) begin
      if (aq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL avg_unexpected got=%0d", avg);
      end else begin
        ae = aq.pop_front();
        chk("avg", {24'd0, avg}, {24'd0, ae[8:1]});
        chk("alarm", {31'd0, alarm}, {31'd0, ae[0]});
      end
    end
    if (bcd_vld) begin
      if (bq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bcd_unexpected got=%0d%0d%0d", bcd_h, bcd_t, bcd_o);
      end else begin
        be = bq.pop_front();
        chk("bcd_digits", {20'd0, bcd_h, bcd_t, bcd_o}, {20'd0, be.d});
        chk("bcd_cycle", cyc, be.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs_a", {20'd0, avg, avg_vld, alarm, bcd_vld, busy}, 0);
    chk("reset_outs_b", {4'd0, bcd_h, bcd_t, bcd_o, tmin, tmax}, 0);
    rst = 1'b1;
    @(negedge clk);
    // window: prime 20, then 40 x4
    send(8'd20, 8'd20, 1'b0, 12, 10);
    send(8'd40, 8'd25, 1'b0, 12, 10);
    send(8'd40, 8'd30, 1'b0, 12, 10);
    send(8'd40, 8'd35, 1'b0, 12, 10);
    send(8'd40, 8'd40, 1'b1, 12, 10);
    // hysteresis: 35 x4 holds, 30 clears once avg < 0x22
    send(8'd35, 8'd38, 1'b1, 12, 10);
    send(8'd35, 8'd37, 1'b1, 12, 10);
    send(8'd35, 8'd36, 1'b1, 12, 10);
    send(8'd35, 8'd35, 1'b1, 12, 10);
    send(8'd30, 8'd33, 1'b0, 12, 10);
    send(8'd30, 8'd32, 1'b0, 12, 10);
    send(8'd30, 8'd31, 1'b0, 12, 10);
    send(8'd30, 8'd30, 1'b0, 12, 10);
    // back-to-back: middle average dropped, last converted after the first completes
    send(8'd50, 8'd35, 1'b0, 0, 10);
    send(8'd50, 8'd40, 1'b1, 0, 0);
    send(8'd50, 8'd45, 1'b1, 20, 17);
    // range: full scale then zero
    send(8'd255, 8'd101, 1'b1, 12, 10);
    send(8'd255, 8'd152, 1'b1, 12, 10);
    send(8'd255, 8'd203, 1'b1, 12, 10);
    send(8'd255, 8'd255, 1'b1, 12, 10);
    send(8'd0, 8'd191, 1'b1, 12, 10);
    send(8'd0, 8'd127, 1'b1, 12, 10);
    send(8'd0, 8'd63, 1'b1, 12, 10);
    send(8'd0, 8'd0, 1'b0, 12, 10);
    // reset in the middle of a conversion: outputs drop at once, aborted value never appears
    send(8'd200, 8'd50, 1'b1, 12, 10);
    send(8'd120, 8'd80, 1'b1, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_outs_a", {27'd0, avg_vld, alarm, bcd_vld, busy, 1'b0}, 0);
    chk("abort_outs_b", {12'd0, avg, bcd_h, bcd_t, bcd_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    send(8'd25, 8'd25, 1'b0, 12, 10);
    // min/max tracking and clear
    send(8'd105, 8'd45, 1'b1, 12, 10);
    send(8'd0, 8'd38, 1'b1, 12, 10);
    send(8'd0, 8'd32, 1'b0, 12, 10);
    send(8'd0, 8'd26, 1'b0, 12, 10);
`ifdef TEMP_MINMAX_EN
    chk("tmin", {24'd0, tmin}, 25);
    chk("tmax", {24'd0, tmax}, 45);
`endif
    send(8'd0, 8'd0, 1'b0, 0, 10);
    mm_clr = 1'b1;
    @(negedge clk);
    mm_clr = 1'b0;
    repeat (11) @(negedge clk);
    send(8'd40, 8'd10, 1'b0, 12, 10);
`ifdef TEMP_MINMAX_EN
    chk("tmin_after_clr", {24'd0, tmin}, 10);
    chk("tmax_after_clr", {24'd0, tmax}, 10);
`else
    chk("tmin_tied", {24'd0, tmin}, 0);
    chk("tmax_tied", {24'd0, tmax}, 0);
`endif
    repeat (4) @(negedge clk);
    chk("avg_queue_drained", aq.size(), 0);
    chk("bcd_queue_drained", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
